// File: rtl/bus_pkg.sv
// Shared types for the bus-merging blocks: arbitration mode selector.
package bus_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: first set request at or above a start index, with wrap,
// or lowest set request when in fixed-priority mode.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   start,
    input  arb_mode_e         mode,
    output logic [CH_W-1:0]   grant,
    output logic              grant_valid
);

    logic [CH_W-1:0]     base;
    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] masked;

    // The upper copy of the requests is left unmasked, so channels below the
    // start index are still found there after the lower copy is exhausted.
    always_comb begin
        base        = (mode == ARB_FIXED) ? '0 : start;
        dbl         = {req, req};
        masked      = dbl;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i < int'(base)) masked[i] = 1'b0;
        end
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_valid = 1'b1;
                grant       = CH_W'((i >= NUM_CH) ? (i - NUM_CH) : i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with one registered output slot; each output
// word carries the index of the channel it came from.
module rr_arb_mux
    import bus_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        valid_i,
    input  logic [NUM_CH*WIDTH-1:0]  data_i,
    output logic [NUM_CH-1:0]        ready_o,
    input  arb_mode_e                mode_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [CH_W-1:0]          ch_o,
    input  logic                     ready_i
);

    // Handshake: a word moves across an interface at a rising edge where both
    // valid and ready are 1. Senders hold valid and payload until that edge;
    // ready may depend combinationally on valid (and ready_o on ready_i).

    logic [CH_W-1:0] last_q;
    logic [CH_W-1:0] start;
    logic [CH_W-1:0] grant;
    logic            grant_valid;
    logic            load;
    logic            take;

    assign start = (last_q == CH_W'(NUM_CH-1)) ? '0 : last_q + CH_W'(1);

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req         (valid_i),
        .start       (start),
        .mode        (mode_i),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // The slot can take a word when empty or when its current word leaves this edge.
    assign load    = !valid_o || ready_i;
    assign take    = load && grant_valid && !rst_i;
    assign ready_o = take ? (NUM_CH'(1) << grant) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            ch_o    <= '0;
            last_q  <= CH_W'(NUM_CH-1);
        end else if (take) begin
            valid_o <= 1'b1;
            data_o  <= data_i[grant*WIDTH +: WIDTH];
            ch_o    <= grant;
            last_q  <= grant;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: expected output words are queued as stimulus is
// issued and popped by a monitor on every output transfer.
module tb_rr_arb_mux;
    import bus_pkg::*;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;
    localparam int CH_W   = 2;
    localparam int W      = CH_W + WIDTH;

    logic                    clk_i;
    logic                    rst_i;
    logic [NUM_CH-1:0]       valid_i;
    logic [NUM_CH*WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]       ready_o;
    arb_mode_e               mode_i;
    logic                    valid_o;
    logic [WIDTH-1:0]        data_o;
    logic [CH_W-1:0]         ch_o;
    logic                    ready_i;

    logic [W-1:0] exp_q[$];
    int compared;
    int mismatched;

    rr_arb_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ch_o    (ch_o),
        .ready_i (ready_i)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_word(input int ch, input logic [WIDTH-1:0] d);
        exp_q.push_back({CH_W'(ch), d});
    endtask

    task automatic set_ch_data(input int ch, input logic [WIDTH-1:0] d);
        data_i[ch*WIDTH +: WIDTH] = d;
    endtask

    // monitor: every output transfer must match the head of the expected queue
    always @(negedge clk_i) begin
        if (!rst_i && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL out_unexpected: got ch=%0d data=%0h expected none", ch_o, data_o);
            end else begin
                check("out_word", {30'd0, ch_o, data_o}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_i      = 1'b1;
        valid_i    = 4'hF;
        ready_i    = 1'b1;
        mode_i     = ARB_RR;
        for (int k = 0; k < NUM_CH; k++) set_ch_data(k, 32'hA0 + k);

        // 1: reset with all channels requesting
        step();
        step();
        @(negedge clk_i);
        check("rst_ready_o", 64'(ready_o), 64'h0);
        check("rst_valid_o", 64'(valid_o), 64'h0);
        check("rst_ch_o",    64'(ch_o),    64'h0);
        step();
        rst_i = 1'b0;

        // 2: round robin, all valid, downstream always ready
        expect_word(0, 32'hA0);
        expect_word(1, 32'hA1);
        expect_word(2, 32'hA2);
        expect_word(3, 32'hA3);
        expect_word(0, 32'hA0);
        @(negedge clk_i);
        check("first_grant_ch0", 64'(ready_o), 64'h1);
        repeat (5) step();
        valid_i = 4'h0;
        step();
        step();
        @(negedge clk_i);
        check("idle_valid_o", 64'(valid_o), 64'h0);

        // 3: backpressure holding a ch2 word
        valid_i = 4'b0100;
        expect_word(2, 32'hA2);
        step();
        valid_i = 4'b0001;
        ready_i = 1'b0;
        expect_word(0, 32'hA0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("stall_ready_o", 64'(ready_o), 64'h0);
            check("stall_valid_o", 64'(valid_o), 64'h1);
            check("stall_data_o",  64'(data_o),  64'hA2);
            check("stall_ch_o",    64'(ch_o),    64'h2);
            step();
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("release_ready_o", 64'(ready_o), 64'h1);
        step();
        valid_i = 4'h0;
        step();
        step();

        // 4: wrap and skip after a ch3 grant
        valid_i = 4'b1000;
        expect_word(3, 32'hA3);
        expect_word(1, 32'hA1);
        expect_word(3, 32'hA3);
        expect_word(1, 32'hA1);
        step();
        valid_i = 4'b1010;
        @(negedge clk_i);
        check("wrap_ready_o", 64'(ready_o), 64'h2);
        repeat (3) step();
        valid_i = 4'h0;
        step();
        step();

        // 5: fixed priority, then back to round robin
        mode_i  = ARB_FIXED;
        valid_i = 4'b0110;
        expect_word(1, 32'hA1);
        expect_word(1, 32'hA1);
        expect_word(1, 32'hA1);
        expect_word(2, 32'hA2);
        @(negedge clk_i);
        check("fixed_ready_o", 64'(ready_o), 64'h2);
        repeat (3) step();
        mode_i = ARB_RR;
        @(negedge clk_i);
        check("rr_resume_ready_o", 64'(ready_o), 64'h4);
        step();
        valid_i = 4'h0;
        step();
        step();

        // 6: reset while a word is held
        ready_i = 1'b0;
        set_ch_data(0, 32'hDEAD);
        valid_i = 4'b0001;
        step();
        valid_i = 4'h0;
        set_ch_data(0, 32'hA0);
        @(negedge clk_i);
        check("held_valid_o", 64'(valid_o), 64'h1);
        check("held_data_o",  64'(data_o),  64'hDEAD);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_valid_o", 64'(valid_o), 64'h0);
        check("midrst_data_o",  64'(data_o),  64'h0);
        ready_i = 1'b1;
        step();
        step();

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
